// File: rtl/seq_divider_ctrl_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding, default width and counter sizing.
package seq_divider_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 4;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v = value - 1;
      while (v > 0) begin
         res = res + 1;
         v = v >> 1;
      end
      if (res < 1) res = 1;
      return res;
   endfunction

endpackage

// File: rtl/seq_divider_ctrl_addsub_unit.sv
// Ripple add/subtract: {cout, sum} = a + (sub ? ~b : b) + cin.
// Carry-out of a subtraction means no borrow (a >= b).
module addsub_unit #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic [N:0]   res
);

   logic [N-1:0] b_eff;

   always_comb begin
      b_eff = sub ? ~b : b;
      res   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, cin};
   end

endmodule

// File: rtl/seq_divider_ctrl.sv
// Sequential restoring unsigned divider: one trial subtraction per cycle,
// start/busy/done handshake, registered quotient/remainder outputs.
module seq_divider_ctrl
   import seq_divider_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = clog2(WIDTH + 1);

   div_state_t state, state_n;

   logic [WIDTH:0]   p, p_n;
   logic [WIDTH-1:0] q, q_n;
   logic [WIDTH-1:0] d, d_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] quo_n, rem_n;
   logic             dbz_n;

   logic [WIDTH:0]   t;
   logic [WIDTH+1:0] sub_res;
   logic             take;

   assign t = {p[WIDTH-1:0], q[WIDTH-1]};

   addsub_unit #(.N(WIDTH + 1)) u_addsub (
      .a   (t),
      .b   ({1'b0, d}),
      .sub (1'b1),
      .cin (1'b1),
      .res (sub_res)
   );

   // p[WIDTH] stays 0 (p < d), so OR-ing it in only guards the shifted-out bit
   assign take = sub_res[WIDTH+1] | p[WIDTH];

   assign busy = (state == S_ITER);
   assign done = (state == S_DONE);

   always_comb begin
      state_n = state;
      p_n     = p;
      q_n     = q;
      d_n     = d;
      cnt_n   = cnt;
      quo_n   = quotient;
      rem_n   = remainder;
      dbz_n   = div_by_zero;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               q_n   = dividend;
               d_n   = divisor;
               p_n   = '0;
               cnt_n = CW'(WIDTH);
               if (divisor == '0) begin
                  state_n = S_DONE;
                  quo_n   = '1;
                  rem_n   = dividend;
                  dbz_n   = 1'b1;
               end else begin
                  state_n = S_ITER;
                  dbz_n   = 1'b0;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_ITER: begin
            if (take) p_n = sub_res[WIDTH:0];
            else      p_n = t;
            q_n   = {q[WIDTH-2:0], take};
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = S_DONE;
               quo_n   = q_n;
               rem_n   = p_n[WIDTH-1:0];
               dbz_n   = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         p           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         p           <= p_n;
         q           <= q_n;
         d           <= d_n;
         cnt         <= cnt_n;
         quotient    <= quo_n;
         remainder   <= rem_n;
         div_by_zero <= dbz_n;
      end
   end

endmodule
